// File: rtl/pipeline_mem.sv
// Memory stage of a 5-stage pipeline: M register, data-memory handshake with timeout,
// and the WB register. Misaligned ops and timed-out requests retire as bubbles.
module pipeline_mem #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        flush,
  input  logic [31:0] aluout,
  input  logic [31:0] memwritedata,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        regwrite,
  input  logic        memtoreg,
  input  logic [4:0]  writereg,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic [4:0]  wb_writereg,
  output logic [31:0] wb_result,
  output logic        misalign,
  output logic        memfault
);

  localparam int DATA_W = 32;
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [0:0]        r_state;
  logic [7:0]        r_cnt;
  logic              r_memfault;

  logic              r_vld_p1;
  logic [DATA_W-1:0] r_addr_p1;
  logic [DATA_W-1:0] r_wdata_p1;
  logic              r_memread_p1;
  logic              r_memwrite_p1;
  logic              r_regwrite_p1;
  logic              r_memtoreg_p1;
  logic [4:0]        r_wreg_p1;

  logic              r_vld_p2;
  logic              r_regwrite_p2;
  logic [4:0]        r_wreg_p2;
  logic [DATA_W-1:0] r_result_p2;

  logic w_access;
  logic w_ack;
  logic w_timeout_hit;
  logic w_stall;
  logic w_cap_access;
  logic w_m_misalign;

  // Ack outside ACCESS is ignored; ack wins over a simultaneous timeout.
  assign w_access      = (r_state == S_ACCESS);
  assign w_ack         = w_access & dmem_ack;
  assign w_timeout_hit = w_access & (r_cnt == CNT_LAST) & ~dmem_ack;
  assign w_stall       = w_access & ~w_ack & ~w_timeout_hit;
  assign w_cap_access  = ex_valid & ~flush & (memread | memwrite) & (aluout[1:0] == 2'b00);
  assign w_m_misalign  = r_vld_p1 & (r_memread_p1 | r_memwrite_p1) & (r_addr_p1[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else if (!w_stall) begin
      r_state <= w_cap_access ? S_ACCESS : S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_cnt   <= r_cnt + 8'd1;
    end
  end

  // EX -> M boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1      <= 1'b0;
      r_addr_p1     <= '0;
      r_wdata_p1    <= '0;
      r_memread_p1  <= 1'b0;
      r_memwrite_p1 <= 1'b0;
      r_regwrite_p1 <= 1'b0;
      r_memtoreg_p1 <= 1'b0;
      r_wreg_p1     <= 5'd0;
    end else if (!w_stall) begin
      r_vld_p1      <= ex_valid & ~flush;
      r_addr_p1     <= aluout;
      r_wdata_p1    <= memwritedata;
      r_memread_p1  <= memread;
      r_memwrite_p1 <= memwrite;
      r_regwrite_p1 <= regwrite;
      r_memtoreg_p1 <= memtoreg;
      r_wreg_p1     <= writereg;
    end
  end

  // M -> WB boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p2      <= 1'b0;
      r_regwrite_p2 <= 1'b0;
      r_wreg_p2     <= 5'd0;
      r_result_p2   <= '0;
      r_memfault    <= 1'b0;
    end else begin
      r_memfault <= w_timeout_hit;
      if (w_stall) begin
        r_vld_p2 <= 1'b0;
      end else begin
        r_vld_p2      <= r_vld_p1 & ~w_m_misalign & ~w_timeout_hit;
        r_regwrite_p2 <= r_regwrite_p1 & (r_wreg_p1 != 5'd0);
        r_wreg_p2     <= r_wreg_p1;
        r_result_p2   <= r_memtoreg_p1 ? dmem_rdata : r_addr_p1;
      end
    end
  end

  assign stall       = w_stall;
  assign dmem_req    = w_access;
  assign dmem_we     = r_memwrite_p1;
  assign dmem_addr   = r_addr_p1;
  assign dmem_wdata  = r_wdata_p1;
  assign misalign    = w_m_misalign;
  assign memfault    = r_memfault;
  assign wb_valid    = r_vld_p2;
  assign wb_regwrite = r_vld_p2 & r_regwrite_p2;
  assign wb_writereg = r_wreg_p2;
  assign wb_result   = r_result_p2;

endmodule

// File: tb/tb_pipeline_mem.sv
// Bench for pipeline_mem: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the memory stage.
module tb_pipeline_mem;

  localparam int T = 4;

  typedef struct packed {
    logic        v;
    logic        fl;
    logic        rd;
    logic        wr;
    logic        rw;
    logic        mtr;
    logic [4:0]  wreg;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ex_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, flush, memread, memwrite, regwrite, memtoreg;
  logic [31:0] aluout, memwritedata, dmem_rdata;
  logic [4:0]  writereg, wb_writereg;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, wb_result;
  logic        wb_valid, wb_regwrite, misalign, memfault;

  pipeline_mem #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .flush(flush),
    .aluout(aluout), .memwritedata(memwritedata), .memread(memread),
    .memwrite(memwrite), .regwrite(regwrite), .memtoreg(memtoreg),
    .writereg(writereg), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
    .wb_writereg(wb_writereg), .wb_result(wb_result), .misalign(misalign),
    .memfault(memfault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the op sitting in M, whether it is waiting on memory and for how long,
  // and what the WB outputs / memfault pulse must show.
  ex_t         m;
  bit          in_flight;
  int          waited;
  logic        e_wv, e_wrw, e_mf;
  logic [4:0]  e_wreg;
  logic [31:0] e_wres;

  logic s_stall, s_req, s_mis, s_mf, s_wv, s_wrw;
  logic [4:0]  s_wreg;
  logic [31:0] s_wres;
  int nreq, nstall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m = '0; in_flight = 0; waited = 0;
    e_wv = 0; e_wrw = 0; e_mf = 0; e_wreg = 0; e_wres = 0;
  endtask

  function automatic ex_t mk(input logic rd, wr, rw, mtr, input logic [4:0] wreg,
                             input logic [31:0] addr, wdata);
    ex_t o;
    o.v = 1; o.fl = 0; o.rd = rd; o.wr = wr; o.rw = rw; o.mtr = mtr;
    o.wreg = wreg; o.addr = addr; o.wdata = wdata;
    return o;
  endfunction

  function automatic ex_t gen();
    ex_t o;
    int k;
    k = int'($urandom_range(0, 3));
    o = mk(0, 0, 0, 0, 5'($urandom), $urandom & 32'hFFFF_FFFC, $urandom);
    case (k)
      0: o.rw = 1;
      1: begin o.rd = 1; o.rw = 1; o.mtr = 1; end
      2: o.wr = 1;
      default: begin
        if ($urandom_range(0, 1) == 1) begin o.rd = 1; o.rw = 1; o.mtr = 1; end
        else o.wr = 1;
        o.addr[1:0] = 2'($urandom_range(1, 3));
      end
    endcase
    o.v = ($urandom_range(0, 99) < 85);
    return o;
  endfunction

  task automatic drive(input ex_t op);
    ex_valid = op.v; flush = op.fl; memread = op.rd; memwrite = op.wr;
    regwrite = op.rw; memtoreg = op.mtr; writereg = op.wreg;
    aluout = op.addr; memwritedata = op.wdata;
  endtask

  // One clock: drive after the falling edge, compare, then advance the model
  // to what the next rising edge must produce.
  task automatic cycle(input ex_t op, input logic ack, input logic [31:0] rd);
    logic x_stall, x_mis, done, gave;
    @(negedge clk);
    drive(op);
    dmem_ack = ack;
    dmem_rdata = rd;
    #1;
    s_stall = stall; s_req = dmem_req; s_mis = misalign; s_mf = memfault;
    s_wv = wb_valid; s_wrw = wb_regwrite; s_wreg = wb_writereg; s_wres = wb_result;
    if (dmem_req) nreq++;
    if (stall) nstall++;

    done    = in_flight && ack;
    gave    = in_flight && !ack && (waited == T - 1);
    x_stall = in_flight && !done && !gave;
    x_mis   = m.v && (m.rd || m.wr) && (m.addr[1:0] != 2'b00);

    chk("stall", 32'(stall), 32'(x_stall));
    chk("dmem_req", 32'(dmem_req), 32'(in_flight));
    if (in_flight) begin
      chk("dmem_we", 32'(dmem_we), 32'(m.wr));
      chk("dmem_addr", dmem_addr, m.addr);
      chk("dmem_wdata", dmem_wdata, m.wdata);
    end
    chk("misalign", 32'(misalign), 32'(x_mis));
    chk("memfault", 32'(memfault), 32'(e_mf));
    chk("wb_valid", 32'(wb_valid), 32'(e_wv));
    chk("wb_regwrite", 32'(wb_regwrite), 32'(e_wrw));
    if (e_wv) begin
      chk("wb_writereg", 32'(wb_writereg), 32'(e_wreg));
      chk("wb_result", wb_result, e_wres);
    end

    if (x_stall) begin
      waited++;
      e_wv = 0; e_wrw = 0; e_mf = 0;
    end else begin
      e_wv   = m.v && !x_mis && !gave;
      e_wrw  = e_wv && m.rw && (m.wreg != 5'd0);
      e_wreg = m.wreg;
      e_wres = m.mtr ? rd : m.addr;
      e_mf   = gave;
      m      = op;
      m.v    = op.v && !op.fl;
      in_flight = m.v && (m.rd || m.wr) && (m.addr[1:0] == 2'b00);
      waited = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    ex_t bub, cur;
    bub = '0;
    reset = 1'b1;
    drive(bub);
    dmem_ack = 0;
    dmem_rdata = 0;
    model_reset();
    #2;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_regwrite", 32'(wb_regwrite), 0);
    chk("rst_misalign", 32'(misalign | memfault), 0);
    chk("rst_buses", dmem_addr | dmem_wdata | wb_result, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // ADD r3: result after two edges, no stall
    nstall = 0;
    cycle(mk(0, 0, 1, 0, 5'd3, 32'h10, 32'h0), 0, 0);
    cycle(bub, 0, 0);
    cycle(bub, 0, 0);
    chk("add_wb_valid", 32'(s_wv), 1);
    chk("add_wb_writereg", 32'(s_wreg), 3);
    chk("add_wb_result", s_wres, 32'h10);
    chk("add_no_stall", nstall, 0);

    // LW r4 @0x100 acked in the third request cycle
    cycle(mk(1, 0, 1, 1, 5'd4, 32'h100, 32'h0), 0, 0);
    nreq = 0; nstall = 0;
    cycle(bub, 0, 0);
    cycle(bub, 0, 0);
    cycle(bub, 1, 32'hDEADBEEF);
    cycle(bub, 0, 0);
    chk("lw_req_cycles", nreq, 3);
    chk("lw_stall_cycles", nstall, 2);
    chk("lw_wb_result", s_wres, 32'hDEADBEEF);
    chk("lw_wb_regwrite", 32'(s_wrw), 1);

    // Misaligned SW @0x102
    nreq = 0;
    cycle(mk(0, 1, 0, 0, 5'd0, 32'h102, 32'h55), 0, 0);
    cycle(bub, 0, 0);
    chk("sw_mis_pulse", 32'(s_mis), 1);
    cycle(bub, 0, 0);
    chk("sw_mis_clear", 32'(s_mis), 0);
    chk("sw_mis_wb_valid", 32'(s_wv), 0);
    chk("sw_mis_no_req", nreq, 0);

    // LW without ack: abandoned after T request cycles
    cycle(mk(1, 0, 1, 1, 5'd7, 32'h200, 32'h0), 0, 0);
    nreq = 0;
    repeat (T) cycle(bub, 0, 0);
    cycle(bub, 0, 0);
    chk("to_req_cycles", nreq, T);
    chk("to_memfault", 32'(s_mf), 1);
    chk("to_stall_released", 32'(s_stall), 0);
    chk("to_wb_valid", 32'(s_wv), 0);
    cycle(bub, 0, 0);
    chk("to_memfault_pulse", 32'(s_mf), 0);

    // Ack on the last allowed cycle retires normally
    cycle(mk(1, 0, 1, 1, 5'd8, 32'h300, 32'h0), 0, 0);
    repeat (T - 1) cycle(bub, 0, 0);
    cycle(bub, 1, 32'h1234_5678);
    cycle(bub, 0, 0);
    chk("ack4_memfault", 32'(s_mf), 0);
    chk("ack4_wb_valid", 32'(s_wv), 1);
    chk("ack4_wb_result", s_wres, 32'h1234_5678);

    // Back-to-back LW/SW/LW acked in their first cycle
    cycle(mk(1, 0, 1, 1, 5'd5, 32'h400, 32'h0), 0, 0);
    cycle(mk(0, 1, 0, 0, 5'd0, 32'h404, 32'hCAFE), 1, 32'hA5A5_0001);
    chk("b2b_req0", 32'(s_req), 1);
    cycle(mk(1, 0, 1, 1, 5'd6, 32'h408, 32'h0), 1, 32'h0);
    chk("b2b_req1", 32'(s_req), 1);
    chk("b2b_wb_lw", s_wres, 32'hA5A5_0001);
    cycle(bub, 1, 32'hA5A5_0002);
    chk("b2b_req2", 32'(s_req), 1);
    chk("b2b_wb_sw", {30'd0, s_wv, s_wrw}, 32'd2);
    cycle(bub, 0, 0);
    chk("b2b_req_end", 32'(s_req), 0);
    chk("b2b_wb_lw2", s_wres, 32'hA5A5_0002);

    // Reset asserted in the middle of an access
    cycle(mk(1, 0, 1, 1, 5'd9, 32'h500, 32'h0), 0, 0);
    cycle(bub, 0, 0);
    #1 reset = 1'b1;
    #1;
    chk("midrst_req", 32'(dmem_req), 0);
    chk("midrst_stall", 32'(stall), 0);
    chk("midrst_wb", 32'(wb_valid | wb_regwrite | memfault), 0);
    model_reset();
    drive(bub);
    dmem_ack = 0;
    @(negedge clk);
    reset = 1'b0;

    // Random traffic, including acks while idle and flushes
    cur = gen();
    for (int i = 0; i < 3000; i++) begin
      logic a;
      cur.fl = ($urandom_range(0, 9) == 0);
      a = in_flight ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 30);
      cycle(cur, a, $urandom);
      if (!s_stall) cur = gen();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_mem.md
PIPELINE_MEM -- requirements
Module: pipeline_mem

Interface
REQ-001 Parameter TIMEOUT, default 16, is the max cycles a data-memory request may stay outstanding; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 ex_valid  input  1  EX result valid (0 = bubble).
REQ-005 flush  input  1  kill the op currently presented by EX.
REQ-006 aluout  input  32  EX ALU result / memory address.
REQ-007 memwritedata  input  32  store data from EX.
REQ-008 memread, memwrite, regwrite, memtoreg  input  1 each  control bits from EX.
REQ-009 writereg  input  5  destination register number.
REQ-010 stall  output  1  hold EX and all upstream stages this cycle.
REQ-011 dmem_req, dmem_we  output  1 each  data-memory request / write enable.
REQ-012 dmem_addr, dmem_wdata  output  32 each  request address / write data.
REQ-013 dmem_rdata  input  32  read data, valid with dmem_ack.
REQ-014 dmem_ack  input  1  memory completes request this cycle.
REQ-015 wb_valid, wb_regwrite  output  1 each  WB op valid / register write enable.
REQ-016 wb_writereg  output  5; wb_result  output  32  to writeback.
REQ-017 misalign, memfault  output  1 each  one-cycle error pulses.

Function
REQ-018 M register (aluout, memwritedata, control, writereg, valid) SHALL load on every edge where stall=0; captured valid = ex_valid & ~flush.
REQ-019 FSM states IDLE, ACCESS; mem op = valid & (memread|memwrite) in M register after capture.
REQ-020 IDLE->ACCESS on the capture edge when the captured op is a mem op with aluout[1:0]==0.
REQ-021 dmem_req SHALL equal (state==ACCESS); dmem_we=memwrite, dmem_addr=aluout, dmem_wdata=memwritedata from M register, stable while dmem_req=1.
REQ-022 dmem_ack is honoured only while dmem_req=1; ack with dmem_req=0 SHALL be ignored.
REQ-023 stall = (state==ACCESS) & ~dmem_ack & ~timeout_hit (combinational).
REQ-024 8-bit wait counter clears on entering ACCESS, increments each ACCESS cycle without ack; timeout_hit = (count==TIMEOUT-1) & ~dmem_ack.
REQ-025 On ack edge: WB register loads, state -> ACCESS if newly captured op is an aligned mem op, else IDLE; back-to-back requests allowed (req stays high).
REQ-026 On timeout_hit edge: request abandoned, memfault=1 for one cycle, op retires as bubble (wb_valid=0).
REQ-027 ack and timeout_hit in same cycle: ack wins, no memfault.
REQ-028 Misaligned mem op (aluout[1:0]!=0): no request, misalign=1 for the cycle it sits in M, retires as bubble; stage does not stall.
REQ-029 Non-mem op in IDLE: WB register loads next edge; latency EX->WB outputs = 2 edges.
REQ-030 wb_result = memtoreg ? dmem_rdata (captured at ack) : aluout.
REQ-031 wb_regwrite = wb_valid & regwrite & (writereg!=0); stores retire with wb_valid=1, wb_regwrite=0.
REQ-032 WB register loads a bubble (wb_valid=0) on any edge where stall=1.
REQ-033 flush SHALL NOT abort an in-flight ACCESS (store side effects are committed).

Reset
REQ-034 Reset SHALL force state=IDLE, counter=0, M and WB valid=0, all outputs 0 (stall, dmem_req, wb_valid, wb_regwrite, misalign, memfault=0; buses 0) without waiting for clk, including mid-ACCESS.
REQ-035 First capture after reset release occurs on the first rising edge with reset=0.

Verification
REQ-036 ADD r3 (aluout=0x10, regwrite=1) -> 2 edges later wb_valid=1, wb_writereg=3, wb_result=0x10, stall never high.
REQ-037 LW r4 @0x100, ack after 3 cycles with rdata=0xDEADBEEF -> dmem_req high 3 cycles, stall high 2, then wb_result=0xDEADBEEF, wb_regwrite=1.
REQ-038 SW @0x102 -> no dmem_req, misalign pulse 1 cycle, wb_valid=0.
REQ-039 LW with no ack, TIMEOUT=4 -> req high exactly 4 cycles, memfault pulse, stall released, wb_valid=0; ack on 4th cycle variant -> normal retire, no memfault.
REQ-040 Back-to-back LW/SW each acked in 1st cycle -> dmem_req continuous, no bubble; reset asserted mid-ACCESS -> dmem_req and stall drop immediately.
